// File: rtl/vram_bus_arbiter_pkg.sv
// Shared video package: requester port map, arbiter state encoding
// and a small width helper used by the VRAM bus arbiter.
package vram_bus_arbiter_pkg;

    localparam int NPORTS   = 3;
    localparam int PORT_L0  = 0;
    localparam int PORT_L1  = 1;
    localparam int PORT_SPR = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Index width for a vector of n ports, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vram_bus_arbiter_rr_select.sv
// Combinational winner pick: first requester at or after ptr (wrapping),
// or lowest-numbered requester when fixed priority is selected.
module rr_select
    import vram_bus_arbiter_pkg::*;
#(
    parameter int NPORTS = vram_bus_arbiter_pkg::NPORTS,
    localparam int IW = idx_w(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     ptr,
    input  logic              fixed,
    output logic [IW-1:0]     idx,
    output logic              valid
);

    int base;
    int c;

    // Scan downward so the nearest port to the start point wins last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        base  = fixed ? 0 : int'(ptr);
        c     = 0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            c = (base + i) % NPORTS;
            if (req[c[IW-1:0]]) begin
                idx   = c[IW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_bus_arbiter.sv
// VRAM bus arbiter: grants one requester at a time to the single VRAM
// port, round-robin or fixed priority, with an IDLE gap between grants.
module vram_bus_arbiter
    import vram_bus_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int NPORTS     = vram_bus_arbiter_pkg::NPORTS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16*NPORTS-1:0] req_addr,
    input  logic [NPORTS-1:0]    req_strobe,
    output logic [NPORTS-1:0]    req_ack,
    output logic [31:0]          req_rddata,
    output logic [15:0]          mem_addr,
    output logic                 mem_strobe,
    input  logic [31:0]          mem_rddata,
    input  logic                 mem_ack,
    input  logic                 line_render_start
);

    localparam int IW = idx_w(NPORTS);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [15:0]       addr_q, addr_d;
    logic              strobe_q, strobe_d;
    logic [NPORTS-1:0] ack_q, ack_d;
    logic [31:0]       rd_q, rd_d;

    logic [IW-1:0]     sel_idx;
    logic              sel_valid;
    logic [15:0]       addr_sel;

    rr_select #(
        .NPORTS (NPORTS)
    ) u_sel (
        .req   (req_strobe),
        .ptr   (rr_q),
        .fixed (FIXED_PRIO != 0),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // Address of the currently selected requester.
    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (sel_idx == IW'(i)) begin
                addr_sel = req_addr[16*i +: 16];
            end
        end
    end

    // Next-state and registered-output logic; acks are single-cycle pulses.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        strobe_d = strobe_q;
        ack_d    = '0;
        rd_d     = rd_q;
        unique case (state_q)
            ST_IDLE: begin
                strobe_d = 1'b0;
                if (sel_valid) begin
                    grant_d  = sel_idx;
                    addr_d   = addr_sel;
                    strobe_d = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    rd_d     = mem_rddata;
                    strobe_d = 1'b0;
                    state_d  = ST_IDLE;
                    for (int i = 0; i < NPORTS; i++) begin
                        ack_d[i] = (grant_q == IW'(i));
                    end
                    if (grant_q == IW'(NPORTS - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = grant_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                strobe_d = 1'b0;
            end
        endcase
        // Line start restarts fairness from layer0, overriding the ack update.
        if (line_render_start) begin
            rr_d = '0;
        end
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            strobe_q <= 1'b0;
            ack_q    <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            strobe_q <= strobe_d;
            ack_q    <= ack_d;
            rd_q     <= rd_d;
        end
    end

    assign req_ack    = ack_q;
    assign req_rddata = rd_q;
    assign mem_addr   = addr_q;
    assign mem_strobe = strobe_q;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Directed bench for vram_bus_arbiter: one round-robin instance and one
// fixed-priority instance, checked with immediate assertions.
module tb_vram_bus_arbiter;
    import vram_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] req_addr;
    logic [2:0]  req_strobe;
    logic [2:0]  req_ack;
    logic [31:0] req_rddata;
    logic [15:0] mem_addr;
    logic        mem_strobe;
    logic [31:0] mem_rddata;
    logic        mem_ack;
    logic        mem_ack_drv;
    logic        zw;
    logic        line_render_start;

    logic [2:0]  req_strobe_fx;
    logic [2:0]  req_ack_fx;
    logic [31:0] req_rddata_fx;
    logic [15:0] mem_addr_fx;
    logic        mem_strobe_fx;
    logic        mem_ack_fx;
    logic        lrs_fx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt[3];
    int fx_cnt[3];
    int order_q[$];
    int time_q[$];
    int snap0;
    int snap2;

    assign mem_ack    = zw ? mem_strobe : mem_ack_drv;
    assign mem_ack_fx = mem_strobe_fx;

    vram_bus_arbiter #(.FIXED_PRIO(0), .NPORTS(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_addr          (req_addr),
        .req_strobe        (req_strobe),
        .req_ack           (req_ack),
        .req_rddata        (req_rddata),
        .mem_addr          (mem_addr),
        .mem_strobe        (mem_strobe),
        .mem_rddata        (mem_rddata),
        .mem_ack           (mem_ack),
        .line_render_start (line_render_start)
    );

    vram_bus_arbiter #(.FIXED_PRIO(1), .NPORTS(3)) dut_fx (
        .clk               (clk),
        .rst               (rst),
        .req_addr          (req_addr),
        .req_strobe        (req_strobe_fx),
        .req_ack           (req_ack_fx),
        .req_rddata        (req_rddata_fx),
        .mem_addr          (mem_addr_fx),
        .mem_strobe        (mem_strobe_fx),
        .mem_rddata        (mem_rddata),
        .mem_ack           (mem_ack_fx),
        .line_render_start (lrs_fx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Record ack pulses mid-cycle and check they are never multi-hot.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ack_onehot", 32'($onehot0(req_ack)), 32'd1);
            for (int i = 0; i < 3; i++) begin
                if (req_ack[i]) begin
                    ack_cnt[i]++;
                    order_q.push_back(i);
                    time_q.push_back(cyc);
                end
                if (req_ack_fx[i]) fx_cnt[i]++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            ack_cnt[i] = 0;
            fx_cnt[i]  = 0;
        end
        rst               = 1'b1;
        req_addr          = '0;
        req_strobe        = '0;
        req_strobe_fx     = '0;
        mem_rddata        = '0;
        mem_ack_drv       = 1'b0;
        zw                = 1'b0;
        line_render_start = 1'b0;
        lrs_fx            = 1'b0;
        #1;
        chk("rst_strobe", 32'(mem_strobe), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_rddata", req_rddata, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single request from the sprite port, 3-cycle memory.
        req_addr[47:32] = 16'h1234;
        req_strobe      = 3'b100;
        tick();
        chk("single_strobe", 32'(mem_strobe), 32'd1);
        chk("single_addr", 32'(mem_addr), 32'h1234);
        tick();
        tick();
        chk("single_hold_strobe", 32'(mem_strobe), 32'd1);
        chk("single_hold_addr", 32'(mem_addr), 32'h1234);
        chk("single_no_early_ack", 32'(req_ack), 32'd0);
        mem_ack_drv = 1'b1;
        mem_rddata  = 32'hCAFE_F00D;
        tick();
        mem_ack_drv = 1'b0;
        req_strobe  = 3'b000;
        chk("single_ack", 32'(req_ack), 32'b100);
        chk("single_rddata", req_rddata, 32'hCAFE_F00D);
        chk("single_strobe_drop", 32'(mem_strobe), 32'd0);
        tick();
        chk("single_ack_pulse", 32'(req_ack), 32'd0);
        tick();
        chk("single_ack_once", 32'(ack_cnt[2]), 32'd1);

        // Round-robin fairness with zero-wait memory.
        order_q.delete();
        time_q.delete();
        req_addr   = {16'h2222, 16'h1111, 16'h0000};
        zw         = 1'b1;
        req_strobe = 3'b111;
        repeat (12) tick();
        req_strobe = 3'b000;
        zw         = 1'b0;
        tick();
        chk("rr_count", 32'(order_q.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < order_q.size())
                chk("rr_order", 32'(order_q[k]), 32'(k % 3));
        end
        for (int k = 1; k < 6; k++) begin
            if (k < time_q.size())
                chk("rr_spacing", 32'(time_q[k] - time_q[k-1]), 32'd2);
        end

        // Line start in the ack cycle of port 0 keeps the pointer at 0.
        req_strobe = 3'b011;
        tick();
        chk("lrs_first_addr", 32'(mem_addr), 32'h0000);
        mem_ack_drv       = 1'b1;
        line_render_start = 1'b1;
        tick();
        mem_ack_drv       = 1'b0;
        line_render_start = 1'b0;
        chk("lrs_ack0", 32'(req_ack), 32'b001);
        tick();
        chk("lrs_regrant_strobe", 32'(mem_strobe), 32'd1);
        chk("lrs_regrant_addr", 32'(mem_addr), 32'h0000);
        mem_ack_drv = 1'b1;
        tick();
        mem_ack_drv = 1'b0;
        req_strobe  = 3'b000;
        chk("lrs_regrant_ack", 32'(req_ack), 32'b001);
        tick();

        // Stray ack while idle is ignored.
        mem_ack_drv = 1'b1;
        tick();
        mem_ack_drv = 1'b0;
        tick();
        chk("stray_no_ack", 32'(req_ack), 32'd0);
        chk("stray_no_strobe", 32'(mem_strobe), 32'd0);

        // Port 1 drops while granted; port 0 arrives during BUSY.
        req_addr[31:16] = 16'hBEEF;
        req_strobe      = 3'b010;
        tick();
        chk("drop_addr", 32'(mem_addr), 32'hBEEF);
        req_addr[15:0]    = 16'h0AAA;
        req_strobe        = 3'b001;
        line_render_start = 1'b1;
        tick();
        line_render_start = 1'b0;
        chk("busy_hold_addr", 32'(mem_addr), 32'hBEEF);
        chk("busy_hold_strobe", 32'(mem_strobe), 32'd1);
        mem_ack_drv = 1'b1;
        mem_rddata  = 32'h1357_2468;
        tick();
        mem_ack_drv = 1'b0;
        chk("drop_ack", 32'(req_ack), 32'b010);
        chk("drop_rddata", req_rddata, 32'h1357_2468);
        tick();
        chk("wait_grant_addr", 32'(mem_addr), 32'h0AAA);
        chk("wait_grant_strobe", 32'(mem_strobe), 32'd1);

        // Reset during BUSY abandons the access.
        rst = 1'b1;
        #1;
        chk("midrst_strobe", 32'(mem_strobe), 32'd0);
        tick();
        req_strobe = 3'b000;
        rst        = 1'b0;
        mem_ack_drv = 1'b1;
        tick();
        mem_ack_drv = 1'b0;
        chk("midrst_no_ack", 32'(req_ack), 32'd0);
        tick();
        chk("midrst_no_ack2", 32'(req_ack), 32'd0);
        chk("midrst_idle", 32'(mem_strobe), 32'd0);

        // Fixed priority: port 2 starves while port 0 requests.
        snap0         = fx_cnt[0];
        snap2         = fx_cnt[2];
        req_strobe_fx = 3'b101;
        repeat (20) tick();
        req_strobe_fx = 3'b100;
        tick();
        chk("fx_port0_acks", 32'(fx_cnt[0] - snap0), 32'd10);
        chk("fx_port2_starved", 32'(fx_cnt[2] - snap2), 32'd0);
        tick();
        tick();
        req_strobe_fx = 3'b000;
        chk("fx_port2_served", 32'(fx_cnt[2] - snap2), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
